regfile_param: RTL and testbench
================================

# regfile_param

Parametrised multi-port register file for the ice-risc integer pipeline. It generalises the 32×32 file to configurable width, depth and read-port count, and adds a second write port, same-cycle write-to-read bypass, a per-register busy scoreboard for hazard detection, and a sequential clear engine that zeroes the file without a reset. It sits between decode (reads, reservations) and writeback (writes).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W
- NREAD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 is hardwired to zero and never busy

- iwClk  in  1  clock; all state updates on rising edge
- iwnRst  in  1  reset, asynchronous, active-low
- iwReadRegs  in  NREAD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W]
- owReadData  out  NREAD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
- owReadBusy  out  NREAD  busy flag of each read register
- iwWe0, iwWe1  in  1  write enables, ports 0 and 1
- iwWriteReg0, iwWriteReg1  in  ADDR_W  write addresses
- iwWriteData0, iwWriteData1  in  DATA_W  write data
- iwReserveEn  in  1  mark iwReserveReg busy (pending producer)
- iwReserveReg  in  ADDR_W  register to reserve
- iwClearReq  in  1  start the clear sweep (single-cycle pulse or level)
- owClearBusy  out  1  clear sweep in progress

## Operation
- Storage: DEPTH×DATA_W array, plus a DEPTH-bit busy vector and an ADDR_W-bit sweep counter.
- Reset (iwnRst=0): all registers 0, all busy bits 0, state IDLE, counter 0, owClearBusy 0. Takes effect immediately, including mid-sweep.
- Write: each enabled port writes on the rising edge. If both ports target the same address, port 1 wins. When ZERO_REG=1, writes to address 0 are dropped.
- Read (combinational): returns 0 if ZERO_REG=1 and the address is 0. Otherwise, if a write this cycle targets the address, it returns that write data (port 1 over port 0). Otherwise it returns the array contents.
- Scoreboard:
  - A write to register r clears busy[r].
  - iwReserveEn sets busy[r].
  - If a reserve and a write hit the same r in the same cycle, the reserve wins and busy stays 1.
  - When ZERO_REG=1, busy[0] stays 0.
- owReadBusy[k] is busy[addr_k] masked by same-cycle bypass: it is 0 if a write to addr_k occurs this cycle, unless a reserve to addr_k also occurs this cycle.
- Clear FSM:
  - IDLE: iwClearReq moves to SWEEP with counter 0.
  - SWEEP: each cycle, writes 0 to reg[counter], clears busy[counter] and increments the counter. After counter = DEPTH-1 it returns to IDLE.
  - owClearBusy = (state == SWEEP).
  - During SWEEP, both write ports and iwReserveEn are ignored.
  - iwClearReq during SWEEP is ignored (no restart).
  - Reads during SWEEP return current array contents, with no bypass.

## Timing
- Read latency 0 (combinational). Write-to-array latency 1 edge; the bypass covers the same cycle.
- Busy set or clear is visible in the array on the cycle after the edge, and visible through bypass in the same cycle.
- Clear sweep takes exactly DEPTH cycles. owClearBusy rises on the edge after iwClearReq is sampled and falls on the edge after the last entry is cleared.
- Counter wraps DEPTH-1 → 0 on exit. The counter width is ADDR_W with no extra bit.
- All outputs are 0 during and immediately after reset. owReadData reflects zeros plus bypass.

## Test plan
- Dual write, same address (defaults):
  - Stimulus: iwWe0=1 with reg 5 ← 0x1111_1111, and iwWe1=1 with reg 5 ← 0x2222_2222; read port 0 = 5 in that cycle and the next.
  - Response: 0x2222_2222 in both cycles.
- Zero register:
  - Stimulus: write 0xDEAD_BEEF to reg 0 on both ports, then reserve reg 0.
  - Response: read of reg 0 = 0 and owReadBusy = 0 at all times.
- Scoreboard:
  - Stimulus: reserve reg 7. Next cycle read 7. Then in one cycle write reg 7 = 0x42 together with a reserve of reg 7. Then write reg 7 = 0x43 alone.
  - Response: busy = 1, 1, then 0 in the cycle of the lone write; data 0x43 is bypassed.
- Clear sweep:
  - Stimulus: fill regs 1..31 with their index, reserve reg 9, pulse iwClearReq.
  - Response: owClearBusy high for exactly 32 cycles; writes issued during the sweep are lost; afterwards all reads = 0 and all busy = 0.
- Reset mid-sweep:
  - Stimulus: assert iwnRst=0 at sweep cycle 10, asynchronously between edges.
  - Response: owClearBusy drops immediately, all regs 0, and a new iwClearReq restarts the sweep from counter 0.
- Parameter variant:
  - Stimulus: DATA_W=16, ADDR_W=3, NREAD=4, ZERO_REG=0; write reg 0 = 0xABCD; read it on all 4 ports.
  - Response: 0xABCD on all ports; the sweep lasts 8 cycles.

Source files
------------

// File: rtl/regfile_param.sv
// regfile_param: parametrised multi-port integer register file for the ice-risc pipeline.
// Two write ports (port 1 has priority), same-cycle write-to-read bypass, a per-register
// busy scoreboard for hazard detection and a sequential clear engine that zeroes the
// whole file one entry per cycle without needing a reset.
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                    iwClk,
  input  logic                    iwnRst,
  input  logic [NREAD*ADDR_W-1:0] iwReadRegs,
  output logic [NREAD*DATA_W-1:0] owReadData,
  output logic [NREAD-1:0]        owReadBusy,
  input  logic                    iwWe0,
  input  logic                    iwWe1,
  input  logic [ADDR_W-1:0]       iwWriteReg0,
  input  logic [ADDR_W-1:0]       iwWriteReg1,
  input  logic [DATA_W-1:0]       iwWriteData0,
  input  logic [DATA_W-1:0]       iwWriteData1,
  input  logic                    iwReserveEn,
  input  logic [ADDR_W-1:0]       iwReserveReg,
  input  logic                    iwClearReq,
  output logic                    owClearBusy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } clear_state_t;

  clear_state_t      state;
  logic [ADDR_W-1:0] sweep_cnt;
  logic              clear_busy;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;

  logic sweeping;
  logic we0_eff;
  logic we1_eff;
  logic rsv_eff;

  // True when the address names the hardwired zero register in this configuration.
  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  assign sweeping    = (state == SWEEP);
  assign owClearBusy = clear_busy;

  // Effective write/reserve requests: the clear engine owns the file while sweeping,
  // and anything aimed at the hardwired zero register is discarded.
  always_comb begin
    we0_eff = iwWe0 && !sweeping && !is_zero_reg(iwWriteReg0);
    we1_eff = iwWe1 && !sweeping && !is_zero_reg(iwWriteReg1);
    rsv_eff = iwReserveEn && !sweeping && !is_zero_reg(iwReserveReg);
  end

  // Clear engine: walks the counter from 0 to DEPTH-1 once per request, then wraps to 0 and idles.
  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) begin
      state      <= IDLE;
      sweep_cnt  <= '0;
      clear_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iwClearReq) begin
            state      <= SWEEP;
            sweep_cnt  <= '0;
            clear_busy <= 1'b1;
          end
        end
        SWEEP: begin
          sweep_cnt <= sweep_cnt + ADDR_W'(1);
          if (sweep_cnt == '1) begin
            state      <= IDLE;
            clear_busy <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          sweep_cnt  <= '0;
          clear_busy <= 1'b0;
        end
      endcase
    end
  end

  // Register array: sweep zeroes one entry per cycle, otherwise port 1 lands last so it wins a tie.
  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (sweeping) begin
      mem[sweep_cnt] <= '0;
    end else begin
      if (we0_eff) begin
        mem[iwWriteReg0] <= iwWriteData0;
      end
      if (we1_eff) begin
        mem[iwWriteReg1] <= iwWriteData1;
      end
    end
  end

  // Busy scoreboard: writes retire a pending producer, a reserve issued alongside a write still wins.
  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) begin
      busy <= '0;
    end else if (sweeping) begin
      busy[sweep_cnt] <= 1'b0;
    end else begin
      if (we0_eff) begin
        busy[iwWriteReg0] <= 1'b0;
      end
      if (we1_eff) begin
        busy[iwWriteReg1] <= 1'b0;
      end
      if (rsv_eff) begin
        busy[iwReserveReg] <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_read
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              bsy;
    logic              hit0;
    logic              hit1;
    logic              hit_rsv;

    assign addr    = iwReadRegs[k*ADDR_W +: ADDR_W];
    assign hit0    = we0_eff && (iwWriteReg0 == addr);
    assign hit1    = we1_eff && (iwWriteReg1 == addr);
    assign hit_rsv = rsv_eff && (iwReserveReg == addr);

    // Combinational read with same-cycle bypass of write data and busy updates.
    always_comb begin
      data = mem[addr];
      bsy  = busy[addr];
      if (is_zero_reg(addr)) begin
        data = '0;
        bsy  = 1'b0;
      end else if (!sweeping) begin
        if (hit1) begin
          data = iwWriteData1;
        end else if (hit0) begin
          data = iwWriteData0;
        end
        if (hit_rsv) begin
          bsy = 1'b1;
        end else if (hit0 || hit1) begin
          bsy = 1'b0;
        end
      end
    end

    assign owReadData[k*DATA_W +: DATA_W] = data;
    assign owReadBusy[k]                  = bsy;
  end

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed, table-driven bench for regfile_param (default and small variant).
module tb_regfile_param;

  logic        iwClk = 1'b0;
  logic        iwnRst;
  logic [9:0]  iwReadRegs;
  logic [63:0] owReadData;
  logic [1:0]  owReadBusy;
  logic        iwWe0, iwWe1;
  logic [4:0]  iwWriteReg0, iwWriteReg1;
  logic [31:0] iwWriteData0, iwWriteData1;
  logic        iwReserveEn;
  logic [4:0]  iwReserveReg;
  logic        iwClearReq;
  logic        owClearBusy;

  logic [11:0] v_readRegs;
  logic [63:0] v_readData;
  logic [3:0]  v_readBusy;
  logic        v_we0, v_we1;
  logic [2:0]  v_writeReg0, v_writeReg1;
  logic [15:0] v_writeData0, v_writeData1;
  logic        v_reserveEn;
  logic [2:0]  v_reserveReg;
  logic        v_clearReq;
  logic        v_clearBusy;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    logic        we0;
    logic [4:0]  wr0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wr1;
    logic [31:0] wd1;
    logic        rsv;
    logic [4:0]  rsvReg;
    logic [4:0]  rd0;
    logic [4:0]  rd1;
    logic [31:0] exp0;
    logic [31:0] exp1;
    logic [1:0]  expBusy;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs[NVEC];

  regfile_param dut (
    .iwClk(iwClk), .iwnRst(iwnRst),
    .iwReadRegs(iwReadRegs), .owReadData(owReadData), .owReadBusy(owReadBusy),
    .iwWe0(iwWe0), .iwWe1(iwWe1),
    .iwWriteReg0(iwWriteReg0), .iwWriteReg1(iwWriteReg1),
    .iwWriteData0(iwWriteData0), .iwWriteData1(iwWriteData1),
    .iwReserveEn(iwReserveEn), .iwReserveReg(iwReserveReg),
    .iwClearReq(iwClearReq), .owClearBusy(owClearBusy)
  );

  regfile_param #(.DATA_W(16), .ADDR_W(3), .NREAD(4), .ZERO_REG(0)) dut_v (
    .iwClk(iwClk), .iwnRst(iwnRst),
    .iwReadRegs(v_readRegs), .owReadData(v_readData), .owReadBusy(v_readBusy),
    .iwWe0(v_we0), .iwWe1(v_we1),
    .iwWriteReg0(v_writeReg0), .iwWriteReg1(v_writeReg1),
    .iwWriteData0(v_writeData0), .iwWriteData1(v_writeData1),
    .iwReserveEn(v_reserveEn), .iwReserveReg(v_reserveReg),
    .iwClearReq(v_clearReq), .owClearBusy(v_clearBusy)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 iwClk = ~iwClk;

  // Hard stop in case something wedges the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
    end
  endtask

  task automatic setIdle();
    iwWe0 = 1'b0; iwWe1 = 1'b0;
    iwWriteReg0 = '0; iwWriteReg1 = '0;
    iwWriteData0 = '0; iwWriteData1 = '0;
    iwReserveEn = 1'b0; iwReserveReg = '0;
    iwClearReq = 1'b0;
    iwReadRegs = '0;
  endtask

  task automatic setIdleV();
    v_we0 = 1'b0; v_we1 = 1'b0;
    v_writeReg0 = '0; v_writeReg1 = '0;
    v_writeData0 = '0; v_writeData1 = '0;
    v_reserveEn = 1'b0; v_reserveReg = '0;
    v_clearReq = 1'b0;
    v_readRegs = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    iwWe0 = v.we0; iwWriteReg0 = v.wr0; iwWriteData0 = v.wd0;
    iwWe1 = v.we1; iwWriteReg1 = v.wr1; iwWriteData1 = v.wd1;
    iwReserveEn = v.rsv; iwReserveReg = v.rsvReg;
    iwClearReq = 1'b0;
    iwReadRegs = {v.rd1, v.rd0};
  endtask

  // Counts sweep cycles after the request pulse; mode 0 probes write/reserve/restart
  // masking mid-sweep, mode 1 probes that a restarted sweep begins at entry 0.
  task automatic runSweep(input int mode, output int len);
    len = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge iwClk);
      setIdle();
      if (mode == 0 && len == 5) begin
        iwWe0 = 1'b1; iwWriteReg0 = 5'd1;  iwWriteData0 = 32'h0000_FFFF;
        iwWe1 = 1'b1; iwWriteReg1 = 5'd20; iwWriteData1 = 32'h0000_BBBB;
        iwReserveEn = 1'b1; iwReserveReg = 5'd2;
        iwReadRegs = {5'd9, 5'd20};
      end
      if (mode == 0 && len == 20) iwClearReq = 1'b1;
      if (mode == 1 && len == 2) iwReadRegs = {5'd3, 5'd1};
      #2;
      if (mode == 0 && len == 5) begin
        checkOutput("sweep_read_no_bypass", owReadData[31:0], 32'd20);
        checkOutput("sweep_busy_held", {30'd0, owReadBusy}, 32'h2);
      end
      if (mode == 1 && len == 2) begin
        checkOutput("restart_reg1_cleared", owReadData[31:0], 32'h0);
        checkOutput("restart_reg3_kept", owReadData[63:32], 32'h77);
      end
      if (owClearBusy !== 1'b1) break;
      len++;
    end
  endtask

  initial begin
    int len;

    vecs[0]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd5, 5'd7, 32'h0,         32'h0,         2'b00};
    vecs[1]  = '{1'b1, 5'd5, 32'h1111_1111, 1'b1, 5'd5, 32'h2222_2222, 1'b0, 5'd0, 5'd5, 5'd3, 32'h2222_2222, 32'h0,         2'b00};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd5, 5'd5, 32'h2222_2222, 32'h2222_2222, 2'b00};
    vecs[3]  = '{1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0,         32'h0,         2'b00};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         1'b1, 5'd0, 5'd0, 5'd0, 32'h0,         32'h0,         2'b00};
    vecs[5]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd0, 5'd5, 32'h0,         32'h2222_2222, 2'b00};
    vecs[6]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         1'b1, 5'd7, 5'd7, 5'd5, 32'h0,         32'h2222_2222, 2'b01};
    vecs[7]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd7, 5'd5, 32'h0,         32'h2222_2222, 2'b01};
    vecs[8]  = '{1'b1, 5'd7, 32'h42,        1'b0, 5'd0, 32'h0,         1'b1, 5'd7, 5'd7, 5'd7, 32'h42,        32'h42,        2'b11};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd7, 5'd5, 32'h42,        32'h2222_2222, 2'b01};
    vecs[10] = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd7, 32'h43,        1'b0, 5'd0, 5'd7, 5'd7, 32'h43,        32'h43,        2'b00};
    vecs[11] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd7, 5'd0, 32'h43,        32'h0,         2'b00};
    vecs[12] = '{1'b1, 5'd3, 32'hA5A5_A5A5, 1'b1, 5'd4, 32'h5A5A_5A5A, 1'b0, 5'd0, 5'd3, 5'd4, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 2'b00};
    vecs[13] = '{1'b1, 5'd4, 32'h1234_5678, 1'b0, 5'd0, 32'h0,         1'b1, 5'd3, 5'd3, 5'd4, 32'hA5A5_A5A5, 32'h1234_5678, 2'b01};
    vecs[14] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 5'd3, 5'd4, 32'hA5A5_A5A5, 32'h1234_5678, 2'b01};

    iwnRst = 1'b0;
    setIdle();
    setIdleV();
    iwReadRegs = {5'd7, 5'd5};
    #7;
    checkOutput("reset_clear_busy", {31'd0, owClearBusy}, 32'h0);
    checkOutput("reset_rd0", owReadData[31:0], 32'h0);
    checkOutput("reset_rd1", owReadData[63:32], 32'h0);
    checkOutput("reset_busy", {30'd0, owReadBusy}, 32'h0);
    @(negedge iwClk);
    iwnRst = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge iwClk);
      applyStimulus(vecs[i]);
      #2;
      checkOutput($sformatf("vec%0d_rd0", i), owReadData[31:0], vecs[i].exp0);
      checkOutput($sformatf("vec%0d_rd1", i), owReadData[63:32], vecs[i].exp1);
      checkOutput($sformatf("vec%0d_busy", i), {30'd0, owReadBusy}, {30'd0, vecs[i].expBusy});
    end

    for (int r = 1; r < 32; r++) begin
      @(negedge iwClk);
      setIdle();
      iwWe0 = 1'b1; iwWriteReg0 = r[4:0]; iwWriteData0 = r;
    end
    @(negedge iwClk);
    setIdle();
    iwReserveEn = 1'b1; iwReserveReg = 5'd9;
    @(negedge iwClk);
    setIdle();
    iwReadRegs = {5'd9, 5'd31};
    #2;
    checkOutput("fill_reg31", owReadData[31:0], 32'd31);
    checkOutput("fill_reg9", owReadData[63:32], 32'd9);
    checkOutput("fill_busy", {30'd0, owReadBusy}, 32'h2);

    @(negedge iwClk);
    setIdle();
    iwClearReq = 1'b1;
    #2;
    checkOutput("clear_req_cycle_idle", {31'd0, owClearBusy}, 32'h0);
    runSweep(0, len);
    checkOutput("sweep_length", len, 32'd32);

    for (int r = 0; r < 32; r++) begin
      @(negedge iwClk);
      setIdle();
      iwReadRegs = {r[4:0], r[4:0]};
      #2;
      checkOutput($sformatf("after_sweep_data_r%0d", r), owReadData[31:0], 32'h0);
      checkOutput($sformatf("after_sweep_busy_r%0d", r), {31'd0, owReadBusy[0]}, 32'h0);
    end

    for (int r = 20; r < 32; r++) begin
      @(negedge iwClk);
      setIdle();
      iwWe0 = 1'b1; iwWriteReg0 = r[4:0]; iwWriteData0 = r + 32'h100;
    end
    @(negedge iwClk);
    setIdle();
    iwReserveEn = 1'b1; iwReserveReg = 5'd30;
    @(negedge iwClk);
    setIdle();
    iwClearReq = 1'b1;
    for (int c = 0; c < 11; c++) begin
      @(negedge iwClk);
      setIdle();
    end
    iwReadRegs = {5'd30, 5'd25};
    #2;
    checkOutput("midsweep_clear_busy", {31'd0, owClearBusy}, 32'h1);
    checkOutput("midsweep_reg25", owReadData[31:0], 32'h119);
    checkOutput("midsweep_busy30", {30'd0, owReadBusy}, 32'h2);
    #1;
    iwnRst = 1'b0;
    #1;
    checkOutput("async_reset_clear_busy", {31'd0, owClearBusy}, 32'h0);
    checkOutput("async_reset_reg25", owReadData[31:0], 32'h0);
    checkOutput("async_reset_busy", {30'd0, owReadBusy}, 32'h0);
    @(negedge iwClk);
    iwnRst = 1'b1;
    @(negedge iwClk);
    setIdle();
    iwWe0 = 1'b1; iwWriteReg0 = 5'd1; iwWriteData0 = 32'h55;
    iwWe1 = 1'b1; iwWriteReg1 = 5'd3; iwWriteData1 = 32'h77;
    @(negedge iwClk);
    setIdle();
    iwClearReq = 1'b1;
    runSweep(1, len);
    checkOutput("restart_sweep_length", len, 32'd32);

    @(negedge iwClk);
    setIdle();
    setIdleV();
    v_we0 = 1'b1; v_writeReg0 = 3'd0; v_writeData0 = 16'hABCD;
    #2;
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("variant_bypass_p%0d", k), {16'd0, v_readData[k*16 +: 16]}, 32'hABCD);
    @(negedge iwClk);
    setIdleV();
    v_reserveEn = 1'b1; v_reserveReg = 3'd0;
    #2;
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("variant_array_p%0d", k), {16'd0, v_readData[k*16 +: 16]}, 32'hABCD);
    checkOutput("variant_reg0_busy", {28'd0, v_readBusy}, 32'hF);
    @(negedge iwClk);
    setIdleV();
    v_clearReq = 1'b1;
    #2;
    checkOutput("variant_busy_held", {28'd0, v_readBusy}, 32'hF);
    len = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge iwClk);
      setIdleV();
      #2;
      if (v_clearBusy !== 1'b1) break;
      len++;
    end
    checkOutput("variant_sweep_length", len, 32'd8);
    checkOutput("variant_after_sweep_data", {16'd0, v_readData[15:0]}, 32'h0);
    checkOutput("variant_after_sweep_busy", {28'd0, v_readBusy}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
